// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Brief    : Shared widths, FSM state type and defaults for io_interconnect.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int c_addr_w  = 32;
    localparam int c_data_w  = 32;
    localparam int c_waddr_w = 30;
    localparam int c_strb_w  = 4;
    localparam int c_count_w = 16;

    localparam logic [31:0] c_unmapped_data_default = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ACK  = 2'd3
    } io_state_t;

endpackage
`default_nettype wire

// File: rtl/io_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : io_addr_decode
// Brief    : Combinational window match; lowest-index matching slave wins.
// Revision : 1.0 - initial release
// ============================================================================
module io_addr_decode
    import io_pkg::*;
#(
    parameter int              N     = 4,
    parameter logic [N*32-1:0] BASES = '0,
    parameter logic [N*32-1:0] MASKS = '0
) (
    input  logic [c_addr_w-1:0] i_addr,
    output logic [N-1:0]        hit,
    output logic                miss
);

    logic [N-1:0] w_match;

    for (genvar gi = 0; gi < N; gi++) begin : g_match
        assign w_match[gi] = ((i_addr & MASKS[32*gi +: 32]) == BASES[32*gi +: 32]);
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    assign miss = ~(|w_match);

endmodule
`default_nettype wire

// File: rtl/io_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : io_interconnect
// Brief    : CPU IO bus to N avalid/aready/bvalid slaves, one transaction in
//            flight, unmapped-access reply and sticky error record.
//            Define IO_INTERCONNECT_TIMEOUT_EN to force-complete hung slaves.
// Revision : 1.0 - initial release
// ============================================================================
module io_interconnect
    import io_pkg::*;
#(
    parameter int              N             = 4,
    parameter logic [N*32-1:0] BASES         = '0,
    parameter logic [N*32-1:0] MASKS         = '0,
    parameter int              TIMEOUT       = 255,
    parameter logic [31:0]     UNMAPPED_DATA = c_unmapped_data_default
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m_addr_strobe,
    input  logic                 m_read_strobe,
    input  logic                 m_write_strobe,
    input  logic [c_addr_w-1:0]  m_addr,
    input  logic [c_strb_w-1:0]  m_byte_enable,
    input  logic [c_data_w-1:0]  m_write_data,
    output logic [c_data_w-1:0]  m_read_data,
    output logic                 m_ready,
    output logic [N-1:0]         s_avalid,
    input  logic [N-1:0]         s_aready,
    output logic                 s_awe,
    output logic [c_waddr_w-1:0] s_aaddr,
    output logic [c_data_w-1:0]  s_adata,
    output logic [c_strb_w-1:0]  s_astrb,
    input  logic [N-1:0]         s_bvalid,
    input  logic [N*32-1:0]      s_bdata,
    output logic                 err,
    output logic [c_addr_w-1:0]  err_addr,
    input  logic                 err_clear
);

    io_state_t            r_state;
    io_state_t            w_state_nxt;
    logic [N-1:0]         r_sel;
    logic [c_addr_w-1:0]  r_addr;
    logic [c_data_w-1:0]  r_wdata;
    logic [c_strb_w-1:0]  r_strb;
    logic                 r_awe;
    logic [c_data_w-1:0]  r_rdata;
    logic                 r_err;
    logic [c_addr_w-1:0]  r_err_addr;

    logic [N-1:0]         w_hit;
    logic                 w_miss;
    logic                 w_start;
    logic                 w_aready;
    logic                 w_bvalid;
    logic [c_data_w-1:0]  w_bdata;
    logic                 w_load;
    logic                 w_rdata_we;
    logic [c_data_w-1:0]  w_rdata_nxt;
    logic                 w_err_set;
    logic [c_addr_w-1:0]  w_err_addr_nxt;
    logic                 w_timeout;

    io_addr_decode #(
        .N     (N),
        .BASES (BASES),
        .MASKS (MASKS)
    ) u_addr_decode (
        .i_addr (m_addr),
        .hit    (w_hit),
        .miss   (w_miss)
    );

    assign w_start  = m_addr_strobe & (m_read_strobe | m_write_strobe);
    assign w_aready = |(s_aready & r_sel);
    assign w_bvalid = |(s_bvalid & r_sel);

    always_comb begin
        w_bdata = '0;
        for (int i = 0; i < N; i++) begin
            if (r_sel[i]) begin
                w_bdata = w_bdata | s_bdata[32*i +: 32];
            end
        end
    end

`ifdef IO_INTERCONNECT_TIMEOUT_EN
    localparam logic [c_count_w-1:0] c_timeout = c_count_w'(TIMEOUT);

    logic [c_count_w-1:0] r_count;
    logic [c_count_w-1:0] w_count_inc;
    logic                 w_busy;

    assign w_busy      = (r_state == ST_REQ) || (r_state == ST_RESP);
    assign w_count_inc = r_count + 1'b1;
    // >= rather than == so a limit crossed while moving REQ->RESP still fires.
    assign w_timeout   = w_busy && (w_count_inc >= c_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_busy) begin
            r_count <= w_count_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_rdata_we     = 1'b0;
        w_rdata_nxt    = w_bdata;
        w_err_set      = 1'b0;
        w_err_addr_nxt = m_addr;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_load = 1'b1;
                    if (w_miss) begin
                        w_state_nxt = ST_ACK;
                        w_rdata_we  = 1'b1;
                        w_rdata_nxt = UNMAPPED_DATA;
                        w_err_set   = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (w_aready && w_bvalid) begin
                    w_state_nxt = ST_ACK;
                    w_rdata_we  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_ACK;
                    w_rdata_we     = 1'b1;
                    w_rdata_nxt    = UNMAPPED_DATA;
                    w_err_set      = 1'b1;
                    w_err_addr_nxt = r_addr;
                end else if (w_aready) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_bvalid) begin
                    w_state_nxt = ST_ACK;
                    w_rdata_we  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_ACK;
                    w_rdata_we     = 1'b1;
                    w_rdata_nxt    = UNMAPPED_DATA;
                    w_err_set      = 1'b1;
                    w_err_addr_nxt = r_addr;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A start while busy is dropped; a same-cycle timeout keeps logging priority.
        if (w_start && (r_state != ST_IDLE) && !w_err_set) begin
            w_err_set      = 1'b1;
            w_err_addr_nxt = m_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_awe   <= 1'b0;
        end else if (w_load) begin
            r_sel   <= w_hit;
            r_addr  <= m_addr;
            r_wdata <= m_write_data;
            r_strb  <= m_byte_enable;
            r_awe   <= m_write_strobe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rdata_we) begin
            r_rdata <= w_rdata_nxt;
        end
    end

    // A clear coinciding with a new error restarts the record at the new address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
            if (!r_err || err_clear) begin
                r_err_addr <= w_err_addr_nxt;
            end
        end else if (err_clear) begin
            r_err <= 1'b0;
        end
    end

    assign s_avalid    = (r_state == ST_REQ) ? r_sel : '0;
    assign s_awe       = r_awe;
    assign s_aaddr     = r_addr[c_addr_w-1:2];
    assign s_adata     = r_wdata;
    assign s_astrb     = r_strb;
    assign m_ready     = (r_state == ST_ACK);
    assign m_read_data = r_rdata;
    assign err         = r_err;
    assign err_addr    = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_io_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_interconnect
// Brief    : Self-checking bench for io_interconnect (N=2) against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_interconnect;

    localparam int          c_n       = 2;
    localparam int          c_timeout = 8;
    localparam logic [31:0] c_unmap   = 32'h0000_0000;
    localparam logic [63:0] c_bases_p = {32'hC200_0100, 32'hC000_0000};
    localparam logic [63:0] c_masks_p = {32'hFFFF_FF00, 32'hFF00_0000};
    localparam logic [31:0] c_base_a [2] = '{32'hC000_0000, 32'hC200_0100};
    localparam logic [31:0] c_mask_a [2] = '{32'hFF00_0000, 32'hFFFF_FF00};

    logic        clk;
    logic        rst_n;
    logic        m_addr_strobe, m_read_strobe, m_write_strobe;
    logic [31:0] m_addr;
    logic [3:0]  m_byte_enable;
    logic [31:0] m_write_data;
    logic [31:0] m_read_data;
    logic        m_ready;
    logic [1:0]  s_avalid;
    logic [1:0]  s_aready;
    logic        s_awe;
    logic [29:0] s_aaddr;
    logic [31:0] s_adata;
    logic [3:0]  s_astrb;
    logic [1:0]  s_bvalid;
    logic [63:0] s_bdata;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clear;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        m_err      = 1'b0;
    logic [31:0] m_err_addr = 32'h0;

    io_interconnect #(
        .N             (c_n),
        .BASES         (c_bases_p),
        .MASKS         (c_masks_p),
        .TIMEOUT       (c_timeout),
        .UNMAPPED_DATA (c_unmap)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_addr_strobe  (m_addr_strobe),
        .m_read_strobe  (m_read_strobe),
        .m_write_strobe (m_write_strobe),
        .m_addr         (m_addr),
        .m_byte_enable  (m_byte_enable),
        .m_write_data   (m_write_data),
        .m_read_data    (m_read_data),
        .m_ready        (m_ready),
        .s_avalid       (s_avalid),
        .s_aready       (s_aready),
        .s_awe          (s_awe),
        .s_aaddr        (s_aaddr),
        .s_adata        (s_adata),
        .s_astrb        (s_astrb),
        .s_bvalid       (s_bvalid),
        .s_bdata        (s_bdata),
        .err            (err),
        .err_addr       (err_addr),
        .err_clear      (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < c_n; i++) begin
            if ((a & c_mask_a[i]) == c_base_a[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_err(input logic [31:0] a);
        if (!m_err) begin
            m_err      = 1'b1;
            m_err_addr = a;
        end
    endtask

    task automatic check_err(input string tag);
        check_eq({tag, "_err"}, {31'b0, err}, {31'b0, m_err});
        if (m_err) check_eq({tag, "_err_addr"}, err_addr, m_err_addr);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        m_err     = 1'b0;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check_eq("clr_err", {31'b0, err}, 32'h0);
    endtask

    // b_lat == 0 means the slave never completes (timeout build only).
    task automatic do_txn(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                          input logic [3:0] be, input int a_lat, input int b_lat,
                          input logic [31:0] bd, input int drop_cyc,
                          input logic [31:0] drop_addr, input bit clr0);
        int         sel;
        int         done;
        bit         timed;
        logic [1:0] exp_av;
        sel   = model_decode(addr);
        timed = (sel >= 0) && (b_lat == 0);
        done  = (sel < 0) ? 1 : (timed ? c_timeout + 1 : b_lat + 1);
        m_addr_strobe  = 1'b1;
        m_read_strobe  = !wr;
        m_write_strobe = wr;
        m_addr         = addr;
        m_write_data   = wd;
        m_byte_enable  = be;
        err_clear      = clr0;
        if (clr0) m_err = 1'b0;
        if (sel < 0) model_err(addr);
        for (int c = 1; c <= done + 1; c++) begin
            @(posedge clk); #1;
            m_addr_strobe  = 1'b0;
            m_read_strobe  = 1'b0;
            m_write_strobe = 1'b0;
            err_clear      = 1'b0;
            s_aready       = 2'b00;
            s_bvalid       = 2'b00;
            s_bdata        = {$urandom, $urandom};
            exp_av = 2'b00;
            if (sel >= 0 && c <= a_lat) exp_av[sel] = 1'b1;
            check_eq("avalid", {30'b0, s_avalid}, {30'b0, exp_av});
            check_eq("ready", {31'b0, m_ready}, {31'b0, (c == done)});
            if (sel >= 0 && c == 1) begin
                check_eq("awe", {31'b0, s_awe}, {31'b0, wr});
                check_eq("aaddr", {2'b0, s_aaddr}, {2'b0, addr[31:2]});
                check_eq("adata", s_adata, wd);
                check_eq("astrb", {28'b0, s_astrb}, {28'b0, be});
            end
            if (c == done) begin
                if (timed) model_err(addr);
                if (sel < 0 || timed) check_eq("rdata_unmapped", m_read_data, c_unmap);
                else if (!wr) check_eq("rdata", m_read_data, bd);
            end
            if (c == done + 1) begin
                check_err("txn");
            end else begin
                if (sel >= 0) begin
                    if (c == a_lat) s_aready[sel] = 1'b1;
                    if (c == b_lat) begin
                        s_bvalid[sel]         = 1'b1;
                        s_bdata[32*sel +: 32] = bd;
                    end
                    s_aready[1-sel] = 1'($urandom);
                    s_bvalid[1-sel] = 1'($urandom);
                end else begin
                    s_aready = 2'($urandom);
                    s_bvalid = 2'($urandom);
                end
                if (c == drop_cyc) begin
                    m_addr_strobe = 1'b1;
                    m_read_strobe = 1'b1;
                    m_addr        = drop_addr;
                    model_err(drop_addr);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          al, bl, dn, dc, kind;
        bit          wr, clr;

        rst_n          = 1'b0;
        m_addr_strobe  = 1'b0;
        m_read_strobe  = 1'b0;
        m_write_strobe = 1'b0;
        m_addr         = '0;
        m_byte_enable  = '0;
        m_write_data   = '0;
        s_aready       = '0;
        s_bvalid       = '0;
        s_bdata        = '0;
        err_clear      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_avalid", {30'b0, s_avalid}, 32'h0);
        check_eq("rst_ready", {31'b0, m_ready}, 32'h0);
        check_eq("rst_rdata", m_read_data, 32'h0);
        check_eq("rst_err", {31'b0, err}, 32'h0);
        check_eq("rst_err_addr", err_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the block's test plan.
        do_txn(32'hC000_0004, 1'b0, 32'h0, 4'h0, 1, 3, 32'h1234_5678, 0, 32'h0, 1'b0);
        do_txn(32'hC200_0104, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 2, 32'h0, 0, 32'h0, 1'b0);
        do_txn(32'hE000_0000, 1'b0, 32'h0, 4'h0, 1, 1, 32'h0, 0, 32'h0, 1'b0);
        do_txn(32'hE100_0000, 1'b0, 32'h0, 4'h0, 1, 1, 32'h0, 0, 32'h0, 1'b0);
        pulse_clear();
        do_txn(32'hC000_0008, 1'b0, 32'h0, 4'hF, 1, 1, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
        do_txn(32'hC000_0010, 1'b0, 32'h0, 4'hF, 2, 4, 32'h0BAD_BEEF, 2, 32'hC200_0100, 1'b0);
        do_txn(32'hC200_01FC, 1'b0, 32'h0, 4'hF, 1, 2, 32'h5555_AAAA, 0, 32'h0, 1'b1);
        do_txn(32'hE200_0000, 1'b0, 32'h0, 4'h0, 1, 1, 32'h0, 0, 32'h0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            case (kind)
                0:       a = {8'hC0, 24'($urandom)};
                1:       a = {24'hC2_0001, 8'($urandom)};
                default: a = $urandom;
            endcase
            wr  = 1'($urandom);
            al  = int'($urandom_range(1, 3));
            bl  = al + int'($urandom_range(0, 3));
            dn  = (model_decode(a) < 0) ? 1 : bl + 1;
            dc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dn)) : 0;
            clr = ($urandom_range(0, 4) == 0);
            do_txn(a, wr, $urandom, 4'($urandom), al, bl, $urandom, dc, $urandom, clr);
        end

`ifdef IO_INTERCONNECT_TIMEOUT_EN
        pulse_clear();
        do_txn(32'hC000_0020, 1'b0, 32'h0, 4'hF, 1, 0, 32'h0, 0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s_bvalid[0]   = 1'b1;
            s_bdata[31:0] = 32'hDDDD_0000;
            @(posedge clk); #1;
            check_eq("late_bvalid_ready", {31'b0, m_ready}, 32'h0);
        end
        s_bvalid = 2'b00;
`endif

        // Leave an error and non-zero read data behind, then reset mid-transaction.
        do_txn(32'hE300_0000, 1'b0, 32'h0, 4'h0, 1, 1, 32'h0, 0, 32'h0, 1'b0);
        do_txn(32'hC000_0040, 1'b0, 32'h0, 4'hF, 1, 1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        m_addr_strobe = 1'b1;
        m_read_strobe = 1'b1;
        m_addr        = 32'hC000_0044;
        @(posedge clk); #1;
        m_addr_strobe = 1'b0;
        m_read_strobe = 1'b0;
        s_aready      = 2'b01;
        @(posedge clk); #1;
        s_aready = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_avalid", {30'b0, s_avalid}, 32'h0);
        check_eq("arst_ready", {31'b0, m_ready}, 32'h0);
        check_eq("arst_rdata", m_read_data, 32'h0);
        check_eq("arst_err", {31'b0, err}, 32'h0);
        check_eq("arst_err_addr", err_addr, 32'h0);
        m_err      = 1'b0;
        m_err_addr = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_bvalid      = 2'b01;
            s_bdata[31:0] = 32'h7777_7777;
            @(posedge clk); #1;
            check_eq("post_rst_ready", {31'b0, m_ready}, 32'h0);
            check_eq("post_rst_avalid", {30'b0, s_avalid}, 32'h0);
        end
        s_bvalid = 2'b00;
        do_txn(32'hC200_0110, 1'b0, 32'h0, 4'hF, 1, 1, 32'h1357_9BDF, 0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
